// File: rtl/vpu_cfg_commit.sv
// -----------------------------------------------------------------------------
// vpu_cfg_commit
//
// Commit queue for scalar results produced by the vector configuration unit
// (CSR reads and the new vl returned by vset[i]vl[i]). The config unit cannot
// be backpressured, so its results land in a small in-order circular FIFO. The
// CPU drains the FIFO through a valid/ready commit port. While the FIFO is
// full, issue is told to hold further config uOPs through cfg_stall_o. A
// result that still arrives while the FIFO is full, with no pop in the same
// cycle, is dropped and recorded in a sticky overflow flag.
//
// Parameters
//   DEPTH              queue entries; a power of two, >= 2
//
// Ports
//   clk_i              clock; all state changes on the rising edge
//   rst_i              synchronous, active-high reset
//   VCFG_read_valid_i  result strobe from the config unit (no backpressure)
//   VCFG_read_data_i   result value (CSR read data or new vl)
//   VCFG_rd_addr_i     destination scalar register, aligned with the strobe
//   VCFG_rd_we_i       the result must be written back (rd != x0)
//   flush_i            discard every queued result
//   commit_ready_i     CPU accepts the head entry this cycle
//   commit_valid_o     head entry valid
//   commit_rd_addr_o   head entry destination (0 while empty)
//   commit_data_o      head entry data (0 while empty)
//   cfg_stall_o        queue full: issue must not send a config uOP
//   count_o            current occupancy
//   overflow_o         sticky: a result was dropped; cleared only by reset
// -----------------------------------------------------------------------------
module vpu_cfg_commit #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     VCFG_read_valid_i,
  input  logic [31:0]              VCFG_read_data_i,
  input  logic [4:0]               VCFG_rd_addr_i,
  input  logic                     VCFG_rd_we_i,
  input  logic                     flush_i,
  input  logic                     commit_ready_i,
  output logic                     commit_valid_o,
  output logic [4:0]               commit_rd_addr_o,
  output logic [31:0]              commit_data_o,
  output logic                     cfg_stall_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Count value that means "every entry occupied".
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic empty;
  logic full;
  logic push_req;   // a result that wants a slot this cycle
  logic pop;        // head entry leaves this cycle
  logic push;       // result actually written into the queue
  logic drop;       // result lost because the queue had no room

  always_comb begin
    empty    = (count == '0);
    full     = (count == FULL_CNT);
    // Results with rd_we clear never need a slot, and a flush cycle discards
    // whatever arrives alongside it.
    push_req = VCFG_read_valid_i && VCFG_rd_we_i && !flush_i;
    pop      = !empty && commit_ready_i && !flush_i;
    // A pop in the same cycle frees the head slot, so a full queue can still
    // accept a push: the write lands in the slot the read pointer is leaving
    // only when the queue is full, which is exactly the slot being popped.
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately left out of reset. Occupancy and
  // pointers decide which entries are meaningful, and the commit outputs are
  // forced to zero while empty, so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{rd_addr: VCFG_rd_addr_i, data: VCFG_read_data_i};
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy and overflow flag
  // ---------------------------------------------------------------------------
  // NOTE: every state register here uses non-blocking assignment so that all
  // of them sample the pre-edge values of push/pop/count together; a blocking
  // update would let one register see another's new value in the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      // Flush empties the queue but keeps the sticky error for software.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: the natural pointer wrap is the modulo-DEPTH wrap.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (drop) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all driven from registered state only, so commit_ready_i and the
  // incoming strobe never reach an output combinationally.
  // ---------------------------------------------------------------------------
  entry_t head;

  // NOTE: head gets a value on every path through this block, otherwise the
  // empty case would hold the previous value and infer a latch.
  always_comb begin
    head = '0;
    if (!empty) begin
      head = mem[rd_ptr];
    end
  end

  assign commit_valid_o   = !empty;
  assign commit_rd_addr_o = head.rd_addr;
  assign commit_data_o    = head.data;
  assign cfg_stall_o      = full;
  assign count_o          = count;
  assign overflow_o       = overflow;

endmodule
